// File: rtl/box_pkg.sv
// Shared types and constants for the frame-synchronous box position controller.
// Holds the FSM encoding, display extents and the clamped step helper.
package box_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CW       = 10;
    localparam int CW1      = CW + 1;

    // One axis move: opposing requests cancel, result saturates at 0 and maxv.
    function automatic logic [CW-1:0] step_clamp(
        input logic [CW-1:0] p,
        input logic          dec,
        input logic          inc,
        input int            step,
        input int            maxv
    );
        logic [CW:0] w;
        logic [CW:0] s;
        logic [CW:0] m;
        w = {1'b0, p};
        s = CW1'(step);
        m = CW1'(maxv);
        step_clamp = p;
        if (dec && !inc) begin
            step_clamp = (w < s) ? '0 : CW'(w - s);
        end else if (inc && !dec) begin
            step_clamp = ((w + s) > m) ? CW'(m) : CW'(w + s);
        end
    endfunction

endpackage

// File: rtl/box_pos_ctrl_if.sv
// Button/VS inputs and committed position outputs of the box controller.
// master drives buttons and VS; slave is the controller.
interface box_pos_ctrl_if;
    import box_pkg::*;

    logic          vs;
    logic          btn_left;
    logic          btn_right;
    logic          btn_up;
    logic          btn_down;
    logic          freeze;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          updated;
    logic          busy;

    modport master (
        output vs, btn_left, btn_right, btn_up, btn_down, freeze,
        input  x, y, updated, busy
    );

    modport slave (
        input  vs, btn_left, btn_right, btn_up, btn_down, freeze,
        output x, y, updated, busy
    );

endinterface

// File: rtl/box_pos_ctrl_dir_tracker.sv
// Per-direction button tracker: edge capture into a pending bit plus a
// saturating hold counter that drives auto-repeat once a full hold is reached.
module dir_tracker #(
    parameter int HOLD_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic commit_i,
    output logic req_o
);

    logic       btn_q;
    logic       pend_q;
    logic       pend_d;
    logic [3:0] hold_q;
    logic [3:0] hold_d;
    logic       rise;
    logic       held_full;

    assign rise      = btn_i & ~btn_q;
    assign held_full = (hold_q == 4'(HOLD_FRAMES));
    assign req_o     = pend_q | held_full;

    // A fresh edge during the commit cycle survives the clear.
    always_comb begin
        pend_d = rise | (pend_q & ~commit_i);
        hold_d = hold_q;
        if (commit_i) begin
            if (!btn_q) begin
                hold_d = '0;
            end else if (!held_full) begin
                hold_d = hold_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q  <= 1'b0;
            pend_q <= 1'b0;
            hold_q <= '0;
        end else begin
            btn_q  <= btn_i;
            pend_q <= pend_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/box_pos_ctrl.sv
// Frame-synchronous box position controller: gathers button requests and
// commits one clamped (x, y) update per VS falling edge so the box never tears.
module box_pos_ctrl
    import box_pkg::*;
#(
    parameter int X_INIT      = 300,
    parameter int Y_INIT      = 167,
    parameter int STEP        = 2,
    parameter int BOX_SIZE    = 200,
    parameter int HOLD_FRAMES = 8
) (
    input logic           clk,
    input logic           rst,
    box_pos_ctrl_if.slave bus
);

    localparam int X_MAX = H_ACTIVE - 1 - BOX_SIZE;
    localparam int Y_MAX = V_ACTIVE - 1 - BOX_SIZE;

    state_t        state_q;
    state_t        state_d;
    logic          vs_d_q;
    logic          frame_start;
    logic          commit;
    logic [3:0]    btn;
    logic [3:0]    req;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic [CW-1:0] nx_q;
    logic [CW-1:0] ny_q;
    logic [CW-1:0] nx_d;
    logic [CW-1:0] ny_d;
    logic          upd_q;

    assign frame_start = vs_d_q & ~bus.vs;
    assign commit      = (state_q == COMMIT);
    assign btn         = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_dir
        dir_tracker #(
            .HOLD_FRAMES(HOLD_FRAMES)
        ) u_dir (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn[i]),
            .commit_i(commit),
            .req_o   (req[i])
        );
    end

    assign nx_d = step_clamp(x_q, req[0], req[1], STEP, X_MAX);
    assign ny_d = step_clamp(y_q, req[2], req[3], STEP, Y_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start && !bus.freeze) state_d = CALC;
            CALC:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // vs_d resets high so a low VS out of reset is not a frame edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vs_d_q  <= 1'b1;
            x_q     <= CW'(X_INIT);
            y_q     <= CW'(Y_INIT);
            nx_q    <= CW'(X_INIT);
            ny_q    <= CW'(Y_INIT);
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_d_q  <= bus.vs;
            upd_q   <= commit;
            if (state_q == CALC) begin
                nx_q <= nx_d;
                ny_q <= ny_d;
            end
            if (commit) begin
                x_q <= nx_q;
                y_q <= ny_q;
            end
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.updated = upd_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_box_pos_ctrl.sv
// Self-checking bench for box_pos_ctrl: vector table plus hold, clamp,
// freeze and reset-abort sequences, with a queue of expected commits.
module tb_box_pos_ctrl;
    import box_pkg::*;

    localparam logic [3:0] PL = 4'b0001;
    localparam logic [3:0] PR = 4'b0010;
    localparam logic [3:0] PU = 4'b0100;
    localparam logic [3:0] PD = 4'b1000;

    typedef struct {
        logic [3:0] press;
        logic       fz;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] btn;
    exp_t sbq[$];
    vec_t tbl[13];
    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int upd_total = 0;

    always #5 clk = ~clk;

    box_pos_ctrl_if bus ();

    assign bus.btn_left  = btn[0];
    assign bus.btn_right = btn[1];
    assign bus.btn_up    = btn[2];
    assign bus.btn_down  = btn[3];

    box_pos_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_total++;
        if (bus.updated === 1'b1) upd_total++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.vs = 1'b1;
        bus.freeze = 1'b0;
        btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input logic [3:0] press, input logic [3:0] held,
                         input logic fz, input logic [9:0] ex,
                         input logic [9:0] ey, input string tag);
        int b0;
        int u0;
        exp_t e;
        bus.freeze = fz;
        if (press != 4'b0) begin
            btn = held | press;
            repeat (3) @(negedge clk);
        end
        btn = held;
        repeat (4) @(negedge clk);
        b0 = busy_total;
        u0 = upd_total;
        if (!fz) sbq.push_back('{x: ex, y: ey});
        bus.vs = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " updated"}, 32'(bus.updated), 32'(!fz));
        if (bus.updated === 1'b1) begin
            chk({tag, " sb_depth"}, 32'(sbq.size()), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({tag, " x"}, 32'(bus.x), 32'(e.x));
                chk({tag, " y"}, 32'(bus.y), 32'(e.y));
            end
        end else begin
            chk({tag, " x"}, 32'(bus.x), 32'(ex));
            chk({tag, " y"}, 32'(bus.y), 32'(ey));
        end
        @(negedge clk);
        bus.vs = 1'b1;
        repeat (4) @(negedge clk);
        chk({tag, " busy_cycles"}, 32'(busy_total - b0), fz ? 32'd0 : 32'd2);
        chk({tag, " upd_pulses"}, 32'(upd_total - u0), fz ? 32'd0 : 32'd1);
    endtask

    initial begin
        int v;
        int u0;
        tbl[0]  = '{press: 4'b0,    fz: 1'b0, ex: 10'd300, ey: 10'd167};
        tbl[1]  = '{press: 4'b0,    fz: 1'b0, ex: 10'd300, ey: 10'd167};
        tbl[2]  = '{press: PR,      fz: 1'b0, ex: 10'd302, ey: 10'd167};
        tbl[3]  = '{press: 4'b0,    fz: 1'b0, ex: 10'd302, ey: 10'd167};
        tbl[4]  = '{press: PU,      fz: 1'b0, ex: 10'd302, ey: 10'd165};
        tbl[5]  = '{press: PD,      fz: 1'b0, ex: 10'd302, ey: 10'd167};
        tbl[6]  = '{press: PL | PR, fz: 1'b0, ex: 10'd302, ey: 10'd167};
        tbl[7]  = '{press: 4'b0,    fz: 1'b0, ex: 10'd302, ey: 10'd167};
        tbl[8]  = '{press: PL | PD, fz: 1'b0, ex: 10'd300, ey: 10'd169};
        tbl[9]  = '{press: PU | PD | PR, fz: 1'b0, ex: 10'd302, ey: 10'd169};
        tbl[10] = '{press: PD,      fz: 1'b1, ex: 10'd302, ey: 10'd169};
        tbl[11] = '{press: 4'b0,    fz: 1'b1, ex: 10'd302, ey: 10'd169};
        tbl[12] = '{press: 4'b0,    fz: 1'b0, ex: 10'd302, ey: 10'd171};

        do_reset();
        chk("reset x", 32'(bus.x), 32'd300);
        chk("reset y", 32'(bus.y), 32'd167);
        chk("reset updated", 32'(bus.updated), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 13; i++) begin
            frame(tbl[i].press, 4'b0, tbl[i].fz, tbl[i].ex, tbl[i].ey,
                  $sformatf("vec%0d", i));
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            v = (i < 8) ? 298 : 298 - 2 * (i - 7);
            frame(4'b0, PL, 1'b0, 10'(v), 10'd167, $sformatf("hold%0d", i));
        end

        do_reset();
        for (int i = 0; i < 71; i++) begin
            v = 300 + 2 * (i + 1);
            if (v > 439) v = 439;
            frame(PR, 4'b0, 1'b0, 10'(v), 10'd167, $sformatf("xmax%0d", i));
        end
        for (int i = 0; i < 221; i++) begin
            v = 439 - 2 * (i + 1);
            if (v < 0) v = 0;
            frame(PL, 4'b0, 1'b0, 10'(v), 10'd167, $sformatf("xmin%0d", i));
        end
        for (int i = 0; i < 85; i++) begin
            v = 167 - 2 * (i + 1);
            if (v < 0) v = 0;
            frame(PU, 4'b0, 1'b0, 10'd0, 10'(v), $sformatf("ymin%0d", i));
        end
        for (int i = 0; i < 141; i++) begin
            v = 2 * (i + 1);
            if (v > 279) v = 279;
            frame(PD, 4'b0, 1'b0, 10'd0, 10'(v), $sformatf("ymax%0d", i));
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            frame(PD, 4'b0, 1'b1, 10'd300, 10'd167, $sformatf("frz%0d", i));
        end
        frame(4'b0, 4'b0, 1'b0, 10'd300, 10'd169, "unfrz");

        btn = PD;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        u0 = upd_total;
        bus.vs = 1'b0;
        @(negedge clk);
        chk("abort busy_in_calc", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.vs = 1'b1;
        @(negedge clk);
        chk("abort y", 32'(bus.y), 32'd167);
        chk("abort x", 32'(bus.x), 32'd300);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort updated", 32'(bus.updated), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort no_pulse", 32'(upd_total - u0), 32'd0);
        chk("abort y_hold", 32'(bus.y), 32'd167);
        frame(4'b0, 4'b0, 1'b0, 10'd300, 10'd167, "post_abort");

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
